pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 108 ++++++++++
 tb/tb_pipe_reg_chain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: multi-stage pipeline register with valid/ready flow control.
//
// A chain of DEPTH register stages, each holding a valid bit and a data word.
// Stage 0 is fed from the upstream port and the last stage drives the downstream
// port. An empty stage always loads, so bubbles collapse toward the output and
// full throughput is kept under backpressure. The ready chain is purely
// combinational; there is no skid buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every stage valid bit
//   in_valid   upstream data valid
//   in_ready   block can accept in_data this cycle
//   in_data    upstream data
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_data   data of the last stage
//   occupancy  registered count of valid stages (0..DEPTH)
module pipe_reg_chain #(
    parameter int unsigned  WIDTH = 16,
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  occupancy
);

    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [CNTW-1:0]  occ_q;

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             tail_full;
    logic             in_xfer;
    logic             out_xfer;

    // A stage may advance unless it and every stage after it are full while
    // the output is stalled. Written without self-reference so the ready
    // chain is a plain AND-reduction per stage.
    always_comb begin
        adv       = '0;
        tail_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tail_full = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                tail_full = tail_full & v_q[j];
            end
            adv[i] = ~tail_full | out_ready;
        end
    end

    // Load source of each stage: the upstream port for stage 0, the previous
    // stage otherwise.
    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v_q[i-1];
            src_d[i] = d_q[i-1];
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~flush;
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else if (flush) begin
            // Data words are left untouched so out_data keeps its last value.
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_q[i] <= src_v[i];
                    // Data only moves with a valid item; bubbles keep old data.
                    if (src_v[i]) begin
                        d_q[i] <= src_d[i];
                    end
                end
            end
            occ_q <= occ_q + CNTW'(in_xfer) - CNTW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a DEPTH=4 and a DEPTH=1 instance share the same
// stimulus. Accepted items go into a per-instance scoreboard tagged with their
// age; the head item is due at the output once it has aged DEPTH-1 edges.
module tb_pipe_reg_chain;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = 16'h0;

    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [15:0] od0, od1;
    logic [2:0]  occ0;
    logic [0:0]  occ1;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .in_data   (in_data),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_data  (od0),
        .occupancy (occ0)
    );

    pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .in_data   (in_data),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_data  (od1),
        .occupancy (occ1)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: circular buffer of accepted items per instance.
    logic [15:0] m_data [2][64];
    int          m_age  [2][64];
    int          m_head [2] = '{0, 0};
    int          m_cnt  [2] = '{0, 0};
    logic [15:0] m_last [2] = '{16'h0, 16'h0};
    bit          accepted;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, id, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; accepted items are pushed with age -1 so
    // they reach age 0 on the edge that captures them.
    task automatic cyc(input logic iv, input logic [15:0] dat, input logic ordy,
                       input logic fl, input logic rst);
        int idx;
        @(negedge clk);
        #1;
        rst_n     = rst;
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
        #1;
        accepted = 1'b0;
        for (int id = 0; id < 2; id++) begin
            if (rst && iv && ir[id]) begin
                idx               = (m_head[id] + m_cnt[id]) % 64;
                m_data[id][idx]   = dat;
                m_age[id][idx]    = -1;
                m_cnt[id]++;
                if (id == 0) accepted = 1'b1;
            end
        end
    endtask

    task automatic mon(input int id);
        int          dep;
        int          nin;
        int          h;
        int          occ;
        bit          hv;
        logic [15:0] od;
        dep = (id == 0) ? 4 : 1;
        od  = (id == 0) ? od0 : od1;
        occ = (id == 0) ? int'(occ0) : int'(occ1);
        if (!rst_n) begin
            chk("rst_out_valid", id, int'(ov[id]), 0);
            chk("rst_out_data", id, int'(od), 0);
            chk("rst_occupancy", id, occ, 0);
            m_cnt[id]  = 0;
            m_last[id] = 16'h0;
            return;
        end
        nin = 0;
        for (int k = 0; k < m_cnt[id]; k++) begin
            if (m_age[id][(m_head[id] + k) % 64] >= 0) nin++;
        end
        h  = m_head[id];
        hv = (nin > 0) && (m_age[id][h] >= dep - 1);
        if (hv) m_last[id] = m_data[id][h];
        chk("in_ready", id, int'(ir[id]), int'(!flush && (nin < dep || out_ready)));
        chk("out_valid", id, int'(ov[id]), int'(!flush && hv));
        chk("out_data", id, int'(od), int'(m_last[id]));
        chk("occupancy", id, occ, nin);
        if (flush) begin
            m_cnt[id] = 0;
            return;
        end
        if (hv && out_ready) begin
            m_head[id] = (h + 1) % 64;
            m_cnt[id]--;
        end
        for (int k = 0; k < m_cnt[id]; k++) begin
            m_age[id][(m_head[id] + k) % 64]++;
        end
    endtask

    always begin
        @(negedge clk);
        #3;
        for (int id = 0; id < 2; id++) mon(id);
    end

    initial begin
        int tries;
        // Reset, then release.
        repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream with the sink always ready.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0, 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Fill under backpressure, fifth push refused, then drain.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hA005, 1'b0, 1'b0, 1'b1);
        tries = 0;
        do begin
            cyc(1'b1, 16'hA005, 1'b1, 1'b0, 1'b1);
            tries++;
        end while (!accepted && tries < 10);
        chk("a005_accepted", 0, int'(accepted), 1);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Sparse input with a toggling sink.
        for (int i = 0; i < 24; i++) begin
            cyc((i % 3) == 0, 16'hB000 + 16'(i), (i % 2) == 0, 1'b0, 1'b1);
        end
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Three items held, then a flush cycle offering 0xBEEF.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset with items in flight, then a fresh push.
        cyc(1'b1, 16'h5551, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h5552, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Continuous input with the sink alternating 0/1.
        for (int i = 0; i < 12; i++) cyc(1'b1, 16'hD000 + 16'(i), i[0], 1'b0, 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0, 1'b1);
        end
        repeat (8) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
